// File: rtl/sprite_blitter.sv
// rtl/sprite_blitter.sv - CHIP-8/SCHIP sprite XOR engine with screen clear and collision flag.
// Sprite fetches, screen read-modify-write and clear all share one memory port.
module sprite_blitter #(
  parameter logic [15:0] SCREEN_START = 16'h100,
  parameter int          SCREEN_W     = 64,
  parameter int          SCREEN_H     = 32,
  parameter int          WRAP         = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        draw,
  input  logic        clear,
  input  logic        wide,
  input  logic [15:0] addr,
  input  logic [3:0]  lines,
  input  logic [7:0]  x,
  input  logic [7:0]  y,
  output logic        ready,
  output logic        collision,
  output logic        mem_read,
  output logic        mem_write,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_write_byte,
  input  logic [7:0]  mem_read_byte
);

  localparam logic [6:0]  COLS_V   = 7'(SCREEN_W / 8);
  localparam logic [6:0]  COL_MASK = 7'(SCREEN_W / 8 - 1);
  localparam logic [15:0] COLS16   = 16'(SCREEN_W / 8);
  localparam logic [8:0]  H_V      = 9'(SCREEN_H);
  localparam logic [7:0]  H_MASK   = 8'(SCREEN_H - 1);
  localparam logic [7:0]  W_MASK   = 8'(SCREEN_W - 1);
  localparam logic [15:0] CLR_LAST = 16'(SCREEN_W * SCREEN_H / 8 - 1);

  typedef enum logic [2:0] {IDLE, FETCH_HI, FETCH_LO, RD, WR, CLR} state_t;
  state_t state, next_state;

  logic        wide_r;
  logic [15:0] sp_addr;
  logic [4:0]  lines_left;
  logic [7:0]  x0;
  logic [7:0]  row;
  logic [7:0]  hi_r, lo_r, old_r;
  logic [1:0]  idx;
  logic [15:0] clr_cnt;

  logic [23:0] pat24;
  logic [7:0]  pat_byte;
  logic [6:0]  col_raw, col_next_raw, col;
  logic [8:0]  row_next;
  logic [15:0] scr_addr;
  logic        last_byte, line_last, row_end;

  // Sprite bits shifted into a 3-byte window; narrow sprites leave the third byte empty.
  always_comb begin
    pat24        = {hi_r, (wide_r ? lo_r : 8'h00), 8'h00} >> x0[2:0];
    pat_byte     = pat24[23:16];
    case (idx)
      2'd0:    pat_byte = pat24[23:16];
      2'd1:    pat_byte = pat24[15:8];
      default: pat_byte = pat24[7:0];
    endcase
    col_raw      = {2'b00, x0[7:3]} + {5'b00000, idx};
    col_next_raw = col_raw + 7'd1;
    col          = (WRAP != 0) ? (col_raw & COL_MASK) : col_raw;
    scr_addr     = SCREEN_START + (16'(row) * COLS16) + {9'b0, col};
    row_next     = {1'b0, row} + 9'd1;
    // Columns only increase along a line, so once one falls off the edge the rest do too.
    last_byte    = (idx == (wide_r ? 2'd2 : 2'd1)) ||
                   ((WRAP == 0) && (col_next_raw >= COLS_V));
    line_last    = (lines_left == 5'd1);
    row_end      = (WRAP == 0) && (row_next >= H_V);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state     = state;
    ready          = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_addr       = 16'h0000;
    mem_write_byte = 8'h00;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (clear)                          next_state = CLR;
        else if (draw && (wide || lines != 4'd0)) next_state = FETCH_HI;
      end
      FETCH_HI: begin
        mem_read   = 1'b1;
        mem_addr   = sp_addr;
        next_state = wide_r ? FETCH_LO : RD;
      end
      FETCH_LO: begin
        mem_read   = 1'b1;
        mem_addr   = sp_addr;
        next_state = RD;
      end
      RD: begin
        mem_read   = 1'b1;
        mem_addr   = scr_addr;
        next_state = WR;
      end
      WR: begin
        mem_write      = 1'b1;
        mem_addr       = scr_addr;
        mem_write_byte = old_r ^ pat_byte;
        if (!last_byte)                next_state = RD;
        else if (line_last || row_end) next_state = IDLE;
        else                           next_state = FETCH_HI;
      end
      CLR: begin
        mem_write  = 1'b1;
        mem_addr   = SCREEN_START + clr_cnt;
        next_state = (clr_cnt == CLR_LAST) ? IDLE : CLR;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      collision  <= 1'b0;
      wide_r     <= 1'b0;
      sp_addr    <= 16'h0000;
      lines_left <= 5'd0;
      x0         <= 8'h00;
      row        <= 8'h00;
      hi_r       <= 8'h00;
      lo_r       <= 8'h00;
      old_r      <= 8'h00;
      idx        <= 2'd0;
      clr_cnt    <= 16'h0000;
    end else begin
      case (state)
        IDLE: if (draw || clear) begin
          collision  <= 1'b0;
          wide_r     <= wide;
          sp_addr    <= addr;
          lines_left <= (lines == 4'd0) ? 5'd16 : {1'b0, lines};
          x0         <= x & W_MASK;
          row        <= y & H_MASK;
          idx        <= 2'd0;
          clr_cnt    <= 16'h0000;
        end
        FETCH_HI: begin
          hi_r    <= mem_read_byte;
          sp_addr <= sp_addr + 16'd1;
        end
        FETCH_LO: begin
          lo_r    <= mem_read_byte;
          sp_addr <= sp_addr + 16'd1;
        end
        RD: old_r <= mem_read_byte;
        WR: begin
          collision <= collision | (|(old_r & pat_byte));
          if (!last_byte) begin
            idx <= idx + 2'd1;
          end else begin
            idx        <= 2'd0;
            lines_left <= lines_left - 5'd1;
            row        <= (WRAP != 0) ? (row_next[7:0] & H_MASK) : row_next[7:0];
          end
        end
        CLR: clr_cnt <= clr_cnt + 16'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// tb/tb_sprite_blitter.sv - self-checking bench for sprite_blitter, clip and wrap instances side by side.
module tb_sprite_blitter;
  localparam int W = 64, H = 32, COLS = W / 8, FB = W * H / 8, START = 'h100;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic draw = 0, clear = 0, wide = 0;
  logic [15:0] addr = 0;
  logic [3:0]  lines = 0;
  logic [7:0]  x = 0, y = 0;
  logic        ready0, coll0, rd0, wr0, ready1, coll1, rd1, wr1;
  logic [15:0] ma0, ma1;
  logic [7:0]  wb0, wb1, rb0, rb1;

  logic [7:0] spr    [0:65535];
  logic [7:0] fbm0   [0:FB-1];
  logic [7:0] fbm1   [0:FB-1];
  logic [7:0] seed_fb[0:FB-1];
  logic [7:0] ref_fb [0:1][0:FB-1];
  logic       fill = 1'b0;
  int checks = 0, errors = 0, viol0 = 0, viol1 = 0;

  sprite_blitter #(.SCREEN_START(16'h100), .SCREEN_W(W), .SCREEN_H(H), .WRAP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .draw(draw), .clear(clear), .wide(wide), .addr(addr),
    .lines(lines), .x(x), .y(y), .ready(ready0), .collision(coll0), .mem_read(rd0),
    .mem_write(wr0), .mem_addr(ma0), .mem_write_byte(wb0), .mem_read_byte(rb0));

  sprite_blitter #(.SCREEN_START(16'h100), .SCREEN_W(W), .SCREEN_H(H), .WRAP(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .draw(draw), .clear(clear), .wide(wide), .addr(addr),
    .lines(lines), .x(x), .y(y), .ready(ready1), .collision(coll1), .mem_read(rd1),
    .mem_write(wr1), .mem_addr(ma1), .mem_write_byte(wb1), .mem_read_byte(rb1));

  function automatic bit in_fb(input logic [15:0] a);
    return (int'(a) >= START) && (int'(a) < START + FB);
  endfunction

  assign rb0 = in_fb(ma0) ? fbm0[8'(ma0 - 16'(START))] : spr[ma0];
  assign rb1 = in_fb(ma1) ? fbm1[8'(ma1 - 16'(START))] : spr[ma1];

  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < FB; i++) fbm0[i] <= seed_fb[i];
    end else if (wr0 && in_fb(ma0)) fbm0[8'(ma0 - 16'(START))] <= wb0;
    viol0 <= viol0 + ((wr0 && !in_fb(ma0)) ? 1 : 0) + ((rd0 && wr0) ? 1 : 0);
  end

  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < FB; i++) fbm1[i] <= seed_fb[i];
    end else if (wr1 && in_fb(ma1)) fbm1[8'(ma1 - 16'(START))] <= wb1;
    viol1 <= viol1 + ((wr1 && !in_fb(ma1)) ? 1 : 0) + ((rd1 && wr1) ? 1 : 0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pixel-level reference: toggles individual screen bits, then counts the bus cycles a line costs.
  task automatic model(input int wr, input bit is_clear, input bit wd, input int a, input int ln,
                       input int xx, input int yy, output int coll, output int cyc);
    int nl, x0, y0, row, px, bi, bt;
    logic [15:0] bits;
    coll = 0;
    cyc  = 0;
    if (is_clear) begin
      for (int i = 0; i < FB; i++) ref_fb[wr][i] = 8'h00;
      cyc = FB;
      return;
    end
    nl = (ln != 0) ? ln : (wd ? 16 : 0);
    x0 = xx % W;
    y0 = yy % H;
    for (int l = 0; l < nl; l++) begin
      row = y0 + l;
      if (wr == 0 && row >= H) break;
      row = row % H;
      if (wd) bits = {spr[(a + 2 * l) % 65536], spr[(a + 2 * l + 1) % 65536]};
      else    bits = {spr[(a + l) % 65536], 8'h00};
      for (int p = 0; p < 16; p++) begin
        if (bits[15 - p]) begin
          px = x0 + p;
          if (wr != 0) px = px % W;
          else if (px >= W) continue;
          bi = row * COLS + px / 8;
          bt = 7 - px % 8;
          if (ref_fb[wr][bi][bt]) coll = 1;
          ref_fb[wr][bi][bt] = ~ref_fb[wr][bi][bt];
        end
      end
      cyc += wd ? 2 : 1;
      for (int i = 0; i < (wd ? 3 : 2); i++)
        if (wr != 0 || x0 / 8 + i < COLS) cyc += 2;
    end
  endtask

  task automatic run(input bit cl, input bit dr, input bit wd, input logic [15:0] a,
                     input logic [3:0] ln, input logic [7:0] xx, input logic [7:0] yy,
                     input string tag);
    int ec0, ec1, ey0, ey1, n0, n1, guard;
    model(0, cl, wd, int'(a), int'(ln), int'(xx), int'(yy), ec0, ey0);
    model(1, cl, wd, int'(a), int'(ln), int'(xx), int'(yy), ec1, ey1);
    @(negedge clk);
    check({tag, "_ready0_pre"}, 32'(ready0), 1);
    check({tag, "_ready1_pre"}, 32'(ready1), 1);
    clear = cl; draw = dr; wide = wd; addr = a; lines = ln; x = xx; y = yy;
    @(negedge clk);
    clear = 0; draw = 0;
    wide = 1'($urandom); addr = 16'($urandom); lines = 4'($urandom);
    x = 8'($urandom); y = 8'($urandom);
    n0 = 0; n1 = 0; guard = 0;
    while ((!ready0 || !ready1) && guard < 5000) begin
      if (!ready0) n0++;
      if (!ready1) n1++;
      guard++;
      @(negedge clk);
    end
    check({tag, "_timeout"}, 32'(guard < 5000), 1);
    check({tag, "_cycles0"}, 32'(n0), 32'(ey0));
    check({tag, "_cycles1"}, 32'(n1), 32'(ey1));
    check({tag, "_coll0"}, 32'(coll0), 32'(ec0));
    check({tag, "_coll1"}, 32'(coll1), 32'(ec1));
    for (int i = 0; i < FB; i++) begin
      check($sformatf("%s_fb0[%0h]", tag, START + i), 32'(fbm0[i]), 32'(ref_fb[0][i]));
      check($sformatf("%s_fb1[%0h]", tag, START + i), 32'(fbm1[i]), 32'(ref_fb[1][i]));
    end
  endtask

  initial begin
    logic [15:0] ra;
    for (int i = 0; i < 65536; i++) spr[i] = 8'($urandom);
    spr[16'h0200] = 8'hFF;
    for (int i = 0; i < 32; i++) spr[16'h0300 + i] = 8'hFF;
    for (int i = 0; i < FB; i++) begin
      seed_fb[i]   = 8'($urandom);
      ref_fb[0][i] = seed_fb[i];
      ref_fb[1][i] = seed_fb[i];
    end
    fill = 1'b1;
    repeat (3) @(negedge clk);
    fill = 1'b0;
    check("rst_ready",  32'(ready0), 1);
    check("rst_coll",   32'(coll0), 0);
    check("rst_rd",     32'(rd0), 0);
    check("rst_wr",     32'(wr0), 0);
    check("rst_addr",   32'(ma0), 0);
    check("rst_wbyte",  32'(wb0), 0);
    rst_n = 1'b1;

    run(1, 0, 0, 16'h0, 4'd0, 8'd0, 8'd0, "clr_init");
    run(0, 1, 0, 16'h0200, 4'd1, 8'd0, 8'd0, "t1");
    check("t1_b100", 32'(fbm0[0]), 32'hFF);
    check("t1_b101", 32'(fbm0[1]), 32'h00);
    check("t1_coll", 32'(coll0), 0);
    run(0, 1, 0, 16'h0200, 4'd1, 8'd0, 8'd0, "t2");
    check("t2_b100", 32'(fbm0[0]), 32'h00);
    check("t2_coll", 32'(coll0), 1);
    run(1, 1, 1, 16'h0300, 4'd0, 8'd3, 8'd0, "t5");
    check("t5_coll", 32'(coll0), 0);
    run(0, 1, 0, 16'h0200, 4'd1, 8'd60, 8'd31, "t3");
    check("t3_clip_1ff", 32'(fbm0[8'hFF]), 32'h0F);
    check("t3_clip_1f8", 32'(fbm0[8'hF8]), 32'h00);
    check("t3_wrap_1ff", 32'(fbm1[8'hFF]), 32'h0F);
    check("t3_wrap_1f8", 32'(fbm1[8'hF8]), 32'hF0);
    run(1, 0, 0, 16'h0, 4'd0, 8'd0, 8'd0, "clr2");
    run(0, 1, 1, 16'h0300, 4'd0, 8'd3, 8'd0, "t4");
    check("t4_r15_b0", 32'(fbm0[15 * COLS + 0]), 32'h1F);
    check("t4_r15_b1", 32'(fbm0[15 * COLS + 1]), 32'hFF);
    check("t4_r15_b2", 32'(fbm0[15 * COLS + 2]), 32'hE0);
    run(0, 1, 0, 16'h0200, 4'd0, 8'd5, 8'd5, "narrow0");
    run(0, 1, 1, 16'hFFFF, 4'd3, 8'd250, 8'd200, "spr_wrap");

    for (int k = 0; k < 24; k++) begin
      ra = 16'h0400 + 16'($urandom_range(0, 16'hFBFF));
      run(($urandom_range(0, 9) == 0), 1'b1, 1'($urandom), ra, 4'($urandom),
          8'($urandom), 8'($urandom), $sformatf("rnd%0d", k));
    end

    @(negedge clk);
    draw = 1; wide = 1; addr = 16'h0300; lines = 4'd0; x = 8'd17; y = 8'd9;
    @(negedge clk);
    draw = 0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(ready0), 1);
    check("mid_rst_coll",  32'(coll0), 0);
    check("mid_rst_rd",    32'(rd0), 0);
    check("mid_rst_wr",    32'(wr0), 0);
    check("mid_rst_addr",  32'(ma0), 0);
    check("mid_rst_wbyte", 32'(wb0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run(1, 0, 0, 16'h0, 4'd0, 8'd0, 8'd0, "clr_post");
    run(0, 1, 1, 16'h0300, 4'd4, 8'd62, 8'd30, "post_rst");

    @(negedge clk);
    check("viol0", 32'(viol0), 0);
    check("viol1", 32'(viol1), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
